// File: rtl/vector_gate_pkg.sv
// Shared types for the OR/NOT vector gate checker: FSM states, expected-output struct and its reference function.
package vector_gate_pkg;

    localparam int VG_W = 3;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} vrc_state_t;

    typedef struct packed {
        logic [VG_W-1:0]   bitwise;
        logic              logical;
        logic [2*VG_W-1:0] not_v;
    } vg_exp_t;

    // Golden behaviour of the gate: OR of both operands, nonzero test, and inverted operands with b on top.
    function automatic vg_exp_t vg_expected(input logic [VG_W-1:0] a, input logic [VG_W-1:0] b);
        vg_exp_t r;
        r.bitwise = a | b;
        r.logical = (a != '0) || (b != '0);
        r.not_v   = {~b, ~a};
        return r;
    endfunction

endpackage

// File: rtl/vector_resp_checker_compare.sv
// vrc_compare: combinational check of one registered gate response against the package reference function.
module vrc_compare
    import vector_gate_pkg::*;
#(
    parameter int W = VG_W
) (
    input  logic [W-1:0]   a_i,
    input  logic [W-1:0]   b_i,
    input  logic [W-1:0]   bitwise_i,
    input  logic           logical_i,
    input  logic [2*W-1:0] not_i,
    output logic           match_o
);

    vg_exp_t exp_s;

    assign exp_s   = vg_expected(a_i, b_i);
    assign match_o = (bitwise_i == exp_s.bitwise) &&
                     (logical_i == exp_s.logical) &&
                     (not_i == exp_s.not_v);

endmodule

// File: rtl/vector_resp_checker.sv
// Self-checking response monitor for the 3-bit OR/NOT gate: two-stage sample/compare pipe with pass/fail counters.
// Optional first-fail capture outputs are built when VRC_FIRST_FAIL_CAPTURE_EN is defined.
module vector_resp_checker
    import vector_gate_pkg::*;
#(
    parameter int W       = VG_W,
    parameter int NUM_VEC = 16,
    localparam int CW     = $clog2(NUM_VEC + 1)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           in_valid,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    input  logic [W-1:0]   out_or_bitwise,
    input  logic           out_or_logical,
    input  logic [2*W-1:0] out_not,
    output logic           busy,
    output logic           done,
    output logic [CW-1:0]  pass_cnt,
    output logic [CW-1:0]  fail_cnt,
    output logic           all_pass,
    output logic [1:0]     dbg_state
`ifdef VRC_FIRST_FAIL_CAPTURE_EN
   ,output logic           ff_valid,
    output logic [CW-1:0]  ff_idx,
    output logic [W-1:0]   ff_a,
    output logic [W-1:0]   ff_b
`endif
);

    localparam logic [CW-1:0] MAX_CNT  = CW'(NUM_VEC);
    localparam logic [CW-1:0] LAST_IDX = CW'(NUM_VEC - 1);

    vrc_state_t     state_q, state_d;
    logic [CW-1:0]  acc_q, acc_d;
    logic [CW-1:0]  pass_q, pass_d;
    logic [CW-1:0]  fail_q, fail_d;
    logic           pipe_vld_q;
    logic [W-1:0]   pa_q, pb_q, pbw_q;
    logic           plg_q;
    logic [2*W-1:0] pnot_q;
    logic           accept, run_start, match;

    // in_valid has no back-pressure: a vector is taken on any edge where it is high in RUN
    // with room left in the run; otherwise it is silently dropped.
    assign accept    = (state_q == ST_RUN) && in_valid && (acc_q < MAX_CNT);
    assign run_start = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_RUN;
            ST_RUN:   if (accept && (acc_q == LAST_IDX)) state_d = ST_DRAIN;
            ST_DRAIN: state_d = ST_DONE;
            ST_DONE:  if (start) state_d = ST_RUN;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            ST_RUN, ST_DRAIN: busy = 1'b1;
            ST_DONE:          done = 1'b1;
            default:          ;
        endcase
    end

    vrc_compare #(.W(W)) u_compare (
        .a_i       (pa_q),
        .b_i       (pb_q),
        .bitwise_i (pbw_q),
        .logical_i (plg_q),
        .not_i     (pnot_q),
        .match_o   (match)
    );

    always_comb begin
        acc_d  = acc_q;
        pass_d = pass_q;
        fail_d = fail_q;
        if (run_start) begin
            acc_d  = '0;
            pass_d = '0;
            fail_d = '0;
        end else begin
            if (accept) acc_d = acc_q + CW'(1);
            if (pipe_vld_q) begin
                if (match && (pass_q < MAX_CNT))       pass_d = pass_q + CW'(1);
                else if (!match && (fail_q < MAX_CNT)) fail_d = fail_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            pass_q <= '0;
            fail_q <= '0;
        end else begin
            acc_q  <= acc_d;
            pass_q <= pass_d;
            fail_q <= fail_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_vld_q <= 1'b0;
            pa_q       <= '0;
            pb_q       <= '0;
            pbw_q      <= '0;
            plg_q      <= 1'b0;
            pnot_q     <= '0;
        end else begin
            pipe_vld_q <= accept;
            if (accept) begin
                pa_q   <= a;
                pb_q   <= b;
                pbw_q  <= out_or_bitwise;
                plg_q  <= out_or_logical;
                pnot_q <= out_not;
            end
        end
    end

    assign pass_cnt  = pass_q;
    assign fail_cnt  = fail_q;
    assign all_pass  = done && (fail_q == '0);
    assign dbg_state = state_q;

`ifdef VRC_FIRST_FAIL_CAPTURE_EN
    logic [CW-1:0] idx_q;
    logic          ffv_q;
    logic [CW-1:0] ffi_q;
    logic [W-1:0]  ffa_q, ffb_q;

    // idx_q travels with the pipe so the captured index is the acceptance order of the failing vector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= '0;
            ffv_q <= 1'b0;
            ffi_q <= '0;
            ffa_q <= '0;
            ffb_q <= '0;
        end else begin
            if (accept) idx_q <= acc_q;
            if (run_start) begin
                ffv_q <= 1'b0;
                ffi_q <= '0;
                ffa_q <= '0;
                ffb_q <= '0;
            end else if (pipe_vld_q && !match && !ffv_q) begin
                ffv_q <= 1'b1;
                ffi_q <= idx_q;
                ffa_q <= pa_q;
                ffb_q <= pb_q;
            end
        end
    end

    assign ff_valid = ffv_q;
    assign ff_idx   = ffi_q;
    assign ff_a     = ffa_q;
    assign ff_b     = ffb_q;
`endif

endmodule

// File: tb/tb_vector_resp_checker.sv
// Bench for vector_resp_checker: directed and randomized gate responses scored against a spec-level model.
// Checks the first-fail outputs too when VRC_FIRST_FAIL_CAPTURE_EN is defined.
module tb_vector_resp_checker;

    localparam int W       = 3;
    localparam int NUM_VEC = 16;
    localparam int CW      = $clog2(NUM_VEC + 1);

    logic           clk = 1'b0;
    logic           rst_n, start, in_valid;
    logic [W-1:0]   a, b, out_or_bitwise;
    logic           out_or_logical;
    logic [2*W-1:0] out_not;
    logic           busy, done, all_pass;
    logic [CW-1:0]  pass_cnt, fail_cnt;
    logic [1:0]     dbg_state;
`ifdef VRC_FIRST_FAIL_CAPTURE_EN
    logic           ff_valid;
    logic [CW-1:0]  ff_idx;
    logic [W-1:0]   ff_a, ff_b;
`endif

    vector_resp_checker #(.W(W), .NUM_VEC(NUM_VEC)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .in_valid       (in_valid),
        .a              (a),
        .b              (b),
        .out_or_bitwise (out_or_bitwise),
        .out_or_logical (out_or_logical),
        .out_not        (out_not),
        .busy           (busy),
        .done           (done),
        .pass_cnt       (pass_cnt),
        .fail_cnt       (fail_cnt),
        .all_pass       (all_pass),
        .dbg_state      (dbg_state)
`ifdef VRC_FIRST_FAIL_CAPTURE_EN
       ,.ff_valid       (ff_valid),
        .ff_idx         (ff_idx),
        .ff_a           (ff_a),
        .ff_b           (ff_b)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Scoreboard: expected verdict per accepted vector, plus running totals and first-fail record.
    logic         exp_q[$];
    int           model_pass, model_fail, acc_n;
    bit           ff_seen;
    int           ff_idx_m;
    logic [W-1:0] ff_a_m, ff_b_m;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_new_run();
        exp_q.delete();
        model_pass = 0;
        model_fail = 0;
        acc_n      = 0;
        ff_seen    = 1'b0;
        ff_idx_m   = 0;
        ff_a_m     = '0;
        ff_b_m     = '0;
    endtask

    task automatic pulse_start();
        start    = 1'b1;
        in_valid = 1'b1;
        a        = 3'd7;
        b        = 3'd7;
        tick();
        start    = 1'b0;
        in_valid = 1'b0;
        model_new_run();
    endtask

    // Present one vector that the model expects to be accepted; checks that counters lag by one edge.
    task automatic drive_raw(input logic [W-1:0] va, input logic [W-1:0] vb,
                             input logic [W-1:0] bw, input logic lg, input logic [2*W-1:0] nt);
        logic ok;
        a              = va;
        b              = vb;
        out_or_bitwise = bw;
        out_or_logical = lg;
        out_not        = nt;
        in_valid       = 1'b1;
        ok = (bw == (va | vb)) && (lg == ((va != 0) || (vb != 0))) && (nt == {~vb, ~va});
        tick();
        in_valid = 1'b0;
        check_eq($sformatf("pass_lag[%0d]", acc_n), 32'(pass_cnt), model_pass);
        check_eq($sformatf("fail_lag[%0d]", acc_n), 32'(fail_cnt), model_fail);
        exp_q.push_back(ok);
        if (ok) model_pass++;
        else begin
            model_fail++;
            if (!ff_seen) begin
                ff_seen  = 1'b1;
                ff_idx_m = acc_n;
                ff_a_m   = va;
                ff_b_m   = vb;
            end
        end
        acc_n++;
    endtask

    // corrupt: 0 = correct gate, 1 = bitwise wrong, 2 = logical wrong, 3 = not wrong
    task automatic drive_vec(input logic [W-1:0] va, input logic [W-1:0] vb, input int corrupt);
        logic [W-1:0]   bw;
        logic           lg;
        logic [2*W-1:0] nt;
        bw = va | vb;
        lg = (va != 0) || (vb != 0);
        nt = {~vb, ~va};
        case (corrupt)
            1:       bw = bw ^ W'($urandom_range(1, 7));
            2:       lg = ~lg;
            3:       nt = nt ^ (2*W)'($urandom_range(1, 63));
            default: ;
        endcase
        drive_raw(va, vb, bw, lg, nt);
    endtask

    task automatic check_end(input string tag);
        check_eq({tag, "_drain_done"}, 32'(done), 0);
        check_eq({tag, "_drain_busy"}, 32'(busy), 1);
        tick();
        check_eq({tag, "_done"}, 32'(done), 1);
        check_eq({tag, "_busy"}, 32'(busy), 0);
        check_eq({tag, "_pass"}, 32'(pass_cnt), model_pass);
        check_eq({tag, "_fail"}, 32'(fail_cnt), model_fail);
        check_eq({tag, "_all_pass"}, 32'(all_pass), (model_fail == 0) ? 1 : 0);
        check_eq({tag, "_scored"}, exp_q.size(), NUM_VEC);
`ifdef VRC_FIRST_FAIL_CAPTURE_EN
        check_eq({tag, "_ff_valid"}, 32'(ff_valid), 32'(ff_seen));
        check_eq({tag, "_ff_idx"}, 32'(ff_idx), ff_seen ? ff_idx_m : 0);
        check_eq({tag, "_ff_a"}, 32'(ff_a), ff_seen ? 32'(ff_a_m) : 0);
        check_eq({tag, "_ff_b"}, 32'(ff_b), ff_seen ? 32'(ff_b_m) : 0);
`endif
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0;
        a = '0; b = '0; out_or_bitwise = '0; out_or_logical = 1'b0; out_not = '0;
        model_new_run();
        repeat (2) tick();
        check_eq("rst_state", 32'(dbg_state), 0);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_done", 32'(done), 0);
        check_eq("rst_pass", 32'(pass_cnt), 0);
        check_eq("rst_fail", 32'(fail_cnt), 0);
        check_eq("rst_all_pass", 32'(all_pass), 0);
        rst_n = 1'b1;
        tick();

        // Run 1: correct gate; start in IDLE carries a valid that must be ignored; start mid-run is ignored.
        pulse_start();
        check_eq("run1_busy", 32'(busy), 1);
        for (int i = 0; i < NUM_VEC; i++) begin
            logic [W-1:0] va, vb;
            va = W'(i % 8);
            vb = (i < 8) ? 3'd6 : 3'd0;
            start = (i == 8);
            if (va == 3'd5 && vb == 3'd6)      drive_raw(va, vb, 3'b111, 1'b1, 6'b001010);
            else if (va == 3'd0 && vb == 3'd0) drive_raw(va, vb, 3'b000, 1'b0, 6'b111111);
            else                               drive_vec(va, vb, 0);
            start = 1'b0;
        end
        check_end("run1");
        check_eq("run1_pass16", 32'(pass_cnt), 16);

        // Extra valids in DONE are dropped.
        for (int i = 0; i < 4; i++) begin
            a = W'($urandom_range(0, 7)); b = W'($urandom_range(0, 7));
            out_or_bitwise = '0; out_or_logical = 1'b0; out_not = '0;
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        check_eq("done_hold_pass", 32'(pass_cnt), 16);
        check_eq("done_hold_fail", 32'(fail_cnt), 0);
        check_eq("done_hold_done", 32'(done), 1);

        // Run 2: restart from DONE, vector 11 (a=3, b=0) reports logical=0.
        start = 1'b1;
        tick();
        start = 1'b0;
        model_new_run();
        check_eq("restart_pass", 32'(pass_cnt), 0);
        check_eq("restart_fail", 32'(fail_cnt), 0);
        check_eq("restart_busy", 32'(busy), 1);
        for (int i = 0; i < NUM_VEC; i++) begin
            logic [W-1:0] va, vb;
            va = W'(i % 8);
            vb = (i < 8) ? 3'd6 : 3'd0;
            drive_vec(va, vb, (i == 11) ? 2 : 0);
        end
        check_end("run2");
        check_eq("run2_fail1", 32'(fail_cnt), 1);
        check_eq("run2_pass15", 32'(pass_cnt), 15);
`ifdef VRC_FIRST_FAIL_CAPTURE_EN
        check_eq("run2_ff_idx11", 32'(ff_idx), 11);
        check_eq("run2_ff_a3", 32'(ff_a), 3);
        check_eq("run2_ff_b0", 32'(ff_b), 0);
`endif

        // Runs 3-4: random operands, random gaps, random corruption.
        for (int r = 0; r < 2; r++) begin
            pulse_start();
            for (int i = 0; i < NUM_VEC; i++) begin
                int gap;
                gap = $urandom_range(0, 3);
                for (int g = 0; g < gap; g++) begin
                    a = W'($urandom_range(0, 7)); b = W'($urandom_range(0, 7));
                    tick();
                    check_eq("gap_pass", 32'(pass_cnt), model_pass);
                    check_eq("gap_fail", 32'(fail_cnt), model_fail);
                end
                drive_vec(W'($urandom_range(0, 7)), W'($urandom_range(0, 7)),
                          ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
            end
            check_end($sformatf("rand%0d", r));
        end

        // Run 5: asynchronous reset after 7 vectors, observed before the next clock edge.
        pulse_start();
        for (int i = 0; i < 7; i++) drive_vec(W'(i), W'(7 - i), (i == 2) ? 1 : 0);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_state", 32'(dbg_state), 0);
        check_eq("arst_pass", 32'(pass_cnt), 0);
        check_eq("arst_fail", 32'(fail_cnt), 0);
        check_eq("arst_done", 32'(done), 0);
        check_eq("arst_busy", 32'(busy), 0);
        tick();
        rst_n = 1'b1;
        tick();
        check_eq("post_rst_state", 32'(dbg_state), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vector_resp_checker.md
Name: vector_resp_checker

Overview:
- Clocked self-checking response monitor for the 3-bit OR/NOT vector gate.
- Sits alongside the gate instance on the bench side, at the opposite end from the stimulus loop.
- Samples each presented (a, b) pair together with the gate's outputs and recomputes the expected values.
- Counts passes and failures over a run of NUM_VEC vectors and flags completion.
- Lets the gate be checked in hardware or in a synthesised self-test wrapper rather than only by reading $monitor logs.

Parameters:
- W, 3, operand width of a and b.
- NUM_VEC, 16, vectors per run; done asserts after this many are checked.
- CW, $clog2(NUM_VEC+1), counter width (derived, not overridable).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a run from IDLE or DONE.
- in_valid  in  1  a, b and the gate outputs are valid this cycle.
- a  in  W  operand a, as driven to the gate.
- b  in  W  operand b, as driven to the gate.
- out_or_bitwise  in  W  gate output under check.
- out_or_logical  in  1  gate output under check.
- out_not  in  2W  gate output under check.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  high in DONE.
- pass_cnt  out  CW  vectors that matched.
- fail_cnt  out  CW  vectors that mismatched.
- all_pass  out  1  done && fail_cnt==0.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - All counters and the pipe register are cleared.
  - busy=0, done=0, pass_cnt=0, fail_cnt=0, all_pass=0.
- Expected values:
  - exp_bitwise = a|b.
  - exp_logical = (a!=0)||(b!=0).
  - exp_not = {~b, ~a}, i.e. out_not[2W-1:W] = ~b and out_not[W-1:0] = ~a.
- A vector passes only if all three outputs match exactly.
- Pipeline:
  - Stage 1 registers a, b and the outputs on an edge where state==RUN, in_valid=1 and accepted count < NUM_VEC.
  - Stage 2 compares and increments pass_cnt or fail_cnt on the next edge.
  - Counter latency is 2 clocks from the in_valid edge.
- FSM:
  - IDLE -> RUN on start. The same edge clears the counters and the accepted count.
  - RUN -> DRAIN on the edge that accepts vector NUM_VEC.
  - DRAIN -> DONE after the pipe stage empties (1 cycle).
  - DONE -> RUN on start, with counters cleared. Otherwise DONE holds and outputs stay frozen.
- in_valid is ignored in IDLE, DRAIN and DONE, and in RUN once NUM_VEC vectors have been accepted.
- start in RUN or DRAIN is ignored; a run cannot be restarted mid-flight.
- start and in_valid on the same edge in IDLE: only start takes effect; that vector is not accepted.
- Counters saturate at NUM_VEC. The invariant pass_cnt + fail_cnt == NUM_VEC holds in DONE.
- rst_n asserted mid-run aborts immediately to IDLE; a partial result is never reported as done.

Optional Feature:
- Macro: VRC_FIRST_FAIL_CAPTURE_EN.
- When defined:
  - Adds outputs ff_valid (1), ff_idx (CW), ff_a (W) and ff_b (W).
  - On the first mismatch of a run, latches that vector's index (0-based acceptance order) and operands, and sets ff_valid.
  - Later mismatches do not overwrite them.
  - All four outputs clear to 0 on reset and on start.
- When undefined:
  - The ports and registers are absent; behaviour is otherwise identical.

Decomposition:
- Package vector_gate_pkg holds:
  - VG_W = 3.
  - typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} vrc_state_t.
  - A function vg_expected(a, b) that returns a packed struct {bitwise, logical, not_v}.
- One natural sub-module: vrc_compare.
  - Purely combinational.
  - Takes the registered vector and expected struct and returns match.
  - Reused by the first-fail capture logic.

Test Plan:
- Reset, then start with W=3, NUM_VEC=16. Drive a=0..7 with b=6, then a=0..7 with b=0, one per cycle, from a correct gate model. Required: done=1, pass_cnt=16, fail_cnt=0, all_pass=1. Spot vectors: a=5, b=6 -> bitwise 3'b111, logical 1, not 6'b001010; a=0, b=0 -> bitwise 3'b000, logical 0, not 6'b111111.
- Force out_or_logical=0 for a=3, b=0 (vector 11). Required: fail_cnt=1, pass_cnt=15, all_pass=0. With VRC_FIRST_FAIL_CAPTURE_EN: ff_idx=11, ff_a=3, ff_b=0.
- Gap the in_valid pulses randomly within the run. Required: counters advance only on valid cycles; done occurs exactly 2 edges after the 16th accepted vector.
- After DONE, drive 4 more in_valid cycles. Required: counters unchanged. Then pulse start. Required: counters read 0 and busy=1 on the next cycle.
- Assert rst_n low after 7 vectors. Required: state=IDLE, counters=0 and done=0 asynchronously, before the next clk edge.
